// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter: BCD MM:SS elapsed-time counter with run/pause/clear
// control and a lap-hold display snapshot.          Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter #(
   parameter int MAX_MIN_TENS = 9
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       second_tick,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   input  logic       ten_sec_mode,
   output logic       timer_enable,
   output logic       ten_sec_enable,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       lap_held,
   output logic       rollover
);

   localparam logic [3:0] C_MT_MAX = 4'(MAX_MIN_TENS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] so_q, st_q, mo_q, mt_q;
   logic [3:0] so_d, st_d, mo_d, mt_d;
   logic [3:0] dso_q, dst_q, dmo_q, dmt_q;
   logic [3:0] dso_d, dst_d, dmo_d, dmt_d;
   logic       held_q, held_d;
   logic       wrap_q, wrap_d;
   logic       ten_q;
   logic       en_q;
   logic       c_st, c_mo, c_mt;

   always_comb begin
      so_d    = so_q;
      st_d    = st_q;
      mo_d    = mo_q;
      mt_d    = mt_q;
      wrap_d  = 1'b0;
      state_d = state_q;
      held_d  = held_q;
      c_st    = 1'b0;
      c_mo    = 1'b0;
      c_mt    = 1'b0;

      // Ten-second mode enters the carry chain at the seconds-tens digit.
      if (state_q == S_RUN && second_tick) begin
         c_st = ten_sec_mode || (so_q == 4'd9);
         if (!ten_sec_mode)
            so_d = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
         if (c_st)
            st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
         c_mo = c_st && (st_q == 4'd5);
         if (c_mo)
            mo_d = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
         c_mt = c_mo && (mo_q == 4'd9);
         if (c_mt) begin
            if (mt_q == C_MT_MAX) begin
               so_d   = 4'd0;
               st_d   = 4'd0;
               mo_d   = 4'd0;
               mt_d   = 4'd0;
               wrap_d = 1'b1;
            end else begin
               mt_d = mt_q + 4'd1;
            end
         end
      end

      if (clear) begin
         state_d = S_IDLE;
         held_d  = 1'b0;
         so_d    = 4'd0;
         st_d    = 4'd0;
         mo_d    = 4'd0;
         mt_d    = 4'd0;
         wrap_d  = 1'b0;
      end else if (start_stop) begin
         state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
      end else if (lap && state_q == S_RUN) begin
         held_d = !held_q;
      end

      // Frozen display keeps its snapshot; otherwise it follows the new count.
      if (held_d && held_q) begin
         dso_d = dso_q;
         dst_d = dst_q;
         dmo_d = dmo_q;
         dmt_d = dmt_q;
      end else begin
         dso_d = so_d;
         dst_d = st_d;
         dmo_d = mo_d;
         dmt_d = mt_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         so_q    <= 4'd0;
         st_q    <= 4'd0;
         mo_q    <= 4'd0;
         mt_q    <= 4'd0;
         dso_q   <= 4'd0;
         dst_q   <= 4'd0;
         dmo_q   <= 4'd0;
         dmt_q   <= 4'd0;
         held_q  <= 1'b0;
         wrap_q  <= 1'b0;
         ten_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         so_q    <= so_d;
         st_q    <= st_d;
         mo_q    <= mo_d;
         mt_q    <= mt_d;
         dso_q   <= dso_d;
         dst_q   <= dst_d;
         dmo_q   <= dmo_d;
         dmt_q   <= dmt_d;
         held_q  <= held_d;
         wrap_q  <= wrap_d;
         ten_q   <= ten_sec_mode;
         en_q    <= (state_d == S_RUN);
      end
   end

   assign timer_enable   = en_q;
   assign running        = en_q;
   assign ten_sec_enable = ten_q;
   assign lap_held       = held_q;
   assign rollover       = wrap_q;
   assign sec_ones       = dso_q;
   assign sec_tens       = dst_q;
   assign min_ones       = dmo_q;
   assign min_tens       = dmt_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter: directed scenarios plus randomized run against a
// seconds-based reference model.                     Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

   localparam int MAX_MT = 9;
   localparam int LAST   = (MAX_MT * 10 + 9) * 60 + 59;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       second_tick, start_stop, clear, lap, ten_sec_mode;
   logic       timer_enable, ten_sec_enable, running, lap_held, rollover;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic [15:0] disp;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: elapsed time as plain seconds.
   int m_state;   // 0 idle, 1 run, 2 pause
   int m_secs;
   int m_disp;
   bit m_held, m_roll, m_ten;

   stopwatch_counter #(.MAX_MIN_TENS(MAX_MT)) dut (
      .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .start_stop(start_stop),
      .clear(clear), .lap(lap), .ten_sec_mode(ten_sec_mode),
      .timer_enable(timer_enable), .ten_sec_enable(ten_sec_enable),
      .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
      .running(running), .lap_held(lap_held), .rollover(rollover)
   );

   always #5 clk = ~clk;

   assign disp = {min_tens, min_ones, sec_tens, sec_ones};

   function automatic logic [15:0] bcd(input int s);
      logic [3:0] a, b, c, d;
      a = 4'(s / 600);
      b = 4'((s / 60) % 10);
      c = 4'((s / 10) % 6);
      d = 4'(s % 10);
      return {a, b, c, d};
   endfunction

   task automatic mdl_reset();
      m_state = 0; m_secs = 0; m_disp = 0; m_held = 0; m_roll = 0; m_ten = 0;
   endtask

   task automatic mdl(input bit tk, input bit ss, input bit cl, input bit lp, input bit md);
      m_ten = md;
      if (cl) begin
         m_state = 0; m_secs = 0; m_held = 0; m_disp = 0; m_roll = 0;
      end else begin
         m_roll = 0;
         if (tk && m_state == 1) begin
            if (!md) begin
               if (m_secs == LAST) begin m_secs = 0; m_roll = 1; end
               else m_secs = m_secs + 1;
            end else begin
               if (m_secs / 10 == LAST / 10) begin m_secs = 0; m_roll = 1; end
               else m_secs = m_secs + 10;
            end
         end
         if (ss) m_state = (m_state == 1) ? 2 : 1;
         else if (lp && m_state == 1) begin
            m_held = !m_held;
            if (m_held) m_disp = m_secs;
         end
         if (!m_held) m_disp = m_secs;
      end
   endtask

   // Called at posedge+1; applies pulses for exactly one sampling edge.
   task automatic step(input bit tk, input bit ss, input bit cl, input bit lp);
      second_tick = tk; start_stop = ss; clear = cl; lap = lp;
      @(posedge clk);
      mdl(tk, ss, cl, lp, ten_sec_mode);
      #1;
      second_tick = 0; start_stop = 0; clear = 0; lap = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0);
   endtask

   task automatic test_reset();
      n_total++;
      if ({disp, timer_enable, ten_sec_enable, running, lap_held, rollover} !== 21'd0)
         $display("FAIL reset_outputs: got %h, expected 0",
                  {disp, timer_enable, ten_sec_enable, running, lap_held, rollover});
      else n_pass++;
   endtask

   task automatic test_count_61();
      bit saw_roll = 0;
      step(0, 1, 0, 0);
      for (int i = 0; i < 61; i++) begin
         step(1, 0, 0, 0);
         if (rollover) saw_roll = 1;
      end
      n_total++;
      if (disp !== 16'h0101) $display("FAIL count61_disp: got %h, expected 0101", disp);
      else n_pass++;
      n_total++;
      if ({running, timer_enable} !== 2'b11)
         $display("FAIL count61_run: got %b, expected 11", {running, timer_enable});
      else n_pass++;
      n_total++;
      if (saw_roll !== 1'b0) $display("FAIL count61_noroll: got %b, expected 0", saw_roll);
      else n_pass++;
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ten_sec_mode = 1; ticks(59);
      ten_sec_mode = 0; ticks(9);
      n_total++;
      if (disp !== 16'h0959) $display("FAIL wrap_0959: got %h, expected 0959", disp);
      else n_pass++;
      ticks(1);
      n_total++;
      if (disp !== 16'h1000) $display("FAIL wrap_1000: got %h, expected 1000", disp);
      else n_pass++;
      ten_sec_mode = 1; ticks(539);
      ten_sec_mode = 0; ticks(9);
      n_total++;
      if ({disp, rollover} !== {16'h9959, 1'b0})
         $display("FAIL wrap_9959: got %h/%b, expected 9959/0", disp, rollover);
      else n_pass++;
      ticks(1);
      n_total++;
      if ({disp, rollover} !== {16'h0000, 1'b1})
         $display("FAIL wrap_roll: got %h/%b, expected 0000/1", disp, rollover);
      else n_pass++;
      step(0, 0, 0, 0);
      n_total++;
      if ({disp, rollover} !== {16'h0000, 1'b0})
         $display("FAIL wrap_roll_once: got %h/%b, expected 0000/0", disp, rollover);
      else n_pass++;
   endtask

   task automatic test_ten_mode();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(7);
      ten_sec_mode = 1;
      n_total++;
      if (ten_sec_enable !== 1'b0) $display("FAIL ten_en_lag: got %b, expected 0", ten_sec_enable);
      else n_pass++;
      ticks(6);
      n_total++;
      if ({disp, ten_sec_enable} !== {16'h0107, 1'b1})
         $display("FAIL ten_count: got %h/%b, expected 0107/1", disp, ten_sec_enable);
      else n_pass++;
      ten_sec_mode = 0;
      n_total++;
      if (ten_sec_enable !== 1'b1) $display("FAIL ten_en_hold: got %b, expected 1", ten_sec_enable);
      else n_pass++;
      step(0, 0, 0, 0);
      ticks(1);
      n_total++;
      if ({disp, ten_sec_enable} !== {16'h0108, 1'b0})
         $display("FAIL ten_back: got %h/%b, expected 0108/0", disp, ten_sec_enable);
      else n_pass++;
   endtask

   task automatic test_pause();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(5);
      step(1, 1, 0, 0);
      n_total++;
      if ({disp, running, timer_enable} !== {16'h0006, 2'b00})
         $display("FAIL pause_enter: got %h/%b, expected 0006/00", disp, {running, timer_enable});
      else n_pass++;
      ticks(3);
      n_total++;
      if ({disp, timer_enable} !== {16'h0006, 1'b0})
         $display("FAIL pause_ignore: got %h/%b, expected 0006/0", disp, timer_enable);
      else n_pass++;
      step(0, 1, 0, 0);
      n_total++;
      if ({running, timer_enable} !== 2'b11)
         $display("FAIL pause_resume: got %b, expected 11", {running, timer_enable});
      else n_pass++;
   endtask

   task automatic test_lap();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(10);
      step(0, 0, 0, 1);
      n_total++;
      if ({disp, lap_held} !== {16'h0010, 1'b1})
         $display("FAIL lap_enter: got %h/%b, expected 0010/1", disp, lap_held);
      else n_pass++;
      ticks(5);
      n_total++;
      if (disp !== 16'h0010) $display("FAIL lap_frozen: got %h, expected 0010", disp);
      else n_pass++;
      step(0, 0, 0, 1);
      n_total++;
      if ({disp, lap_held} !== {16'h0015, 1'b0})
         $display("FAIL lap_exit: got %h/%b, expected 0015/0", disp, lap_held);
      else n_pass++;
   endtask

   task automatic test_clear_and_reset();
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(42);
      step(0, 0, 0, 1);
      step(1, 1, 1, 0);
      n_total++;
      if ({disp, running, timer_enable, lap_held} !== {16'h0000, 3'b000})
         $display("FAIL clear_coincident: got %h/%b, expected 0000/000",
                  disp, {running, timer_enable, lap_held});
      else n_pass++;
      step(0, 1, 0, 0);
      ten_sec_mode = 1;
      ticks(20);
      step(0, 0, 0, 1);
      #3 n_rst = 0;
      #1;
      n_total++;
      if ({disp, timer_enable, ten_sec_enable, running, lap_held, rollover} !== 21'd0)
         $display("FAIL async_reset: got %h, expected 0",
                  {disp, timer_enable, ten_sec_enable, running, lap_held, rollover});
      else n_pass++;
      ten_sec_mode = 0;
      #2 n_rst = 1;
      mdl_reset();
      step(0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [20:0] got, exp;
      bit tk, ss, cl, lp;
      step(0, 0, 1, 0);
      for (int i = 0; i < 800; i++) begin
         tk = ($urandom_range(99) < 55);
         ss = ($urandom_range(99) < 6);
         cl = ($urandom_range(99) < 2);
         lp = !tk && ($urandom_range(99) < 8);
         if ($urandom_range(99) < 4) ten_sec_mode = !ten_sec_mode;
         step(tk, ss, cl, lp);
         got = {disp, running, timer_enable, lap_held, rollover, ten_sec_enable};
         exp = {bcd(m_disp), m_state == 1, m_state == 1, m_held, m_roll, m_ten};
         n_total++;
         if (got !== exp) $display("FAIL random_cycle%0d: got %h, expected %h", i, got, exp);
         else n_pass++;
      end
   endtask

   initial begin
      n_rst = 0; second_tick = 0; start_stop = 0; clear = 0; lap = 0; ten_sec_mode = 0;
      mdl_reset();
      #12;
      test_reset();
      n_rst = 1;
      @(posedge clk); #1;
      test_reset();
      test_count_61();
      test_wrap();
      test_ten_mode();
      test_pause();
      test_lap();
      test_clear_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
